// File: rtl/stepper_phase_driver_if.sv
// Move-command handshake between the command source and the stepper driver.
`timescale 1ns/1ps
interface stepper_phase_driver_if #(
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;

    modport master (output cmd_valid, output cmd_steps, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_steps, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/stepper_phase_driver.sv
// Unipolar 4-wire stepper driver: turns divider ticks into coil phase patterns,
// runs counted moves from a valid/ready command port, tracks signed position.
`timescale 1ns/1ps
module stepper_phase_driver #(
    parameter int STEP_W = 16,
    parameter int POS_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,      // async, active low
    input  logic                 step_tick,
    input  logic                 enable,
    input  logic                 half_step,
    input  logic                 abort,
    stepper_phase_driver_if.slave cmd,
    output logic [3:0]           coil,
    output logic                 busy,
    output logic                 done,
    output logic [POS_W-1:0]     position
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [3:0]        coil_q, coil_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              counted;

    // Half-step phase table; full-step uses the odd (two-coil) entries.
    function automatic logic [3:0] phase_pat(input logic [2:0] i);
        case (i)
            3'd0:    phase_pat = 4'b1000;
            3'd1:    phase_pat = 4'b1100;
            3'd2:    phase_pat = 4'b0100;
            3'd3:    phase_pat = 4'b0110;
            3'd4:    phase_pat = 4'b0010;
            3'd5:    phase_pat = 4'b0011;
            3'd6:    phase_pat = 4'b0001;
            default: phase_pat = 4'b1001;
        endcase
    endfunction

    // Next table index; full-step snaps an even index onto the odd sequence.
    function automatic logic [2:0] next_idx(input logic [2:0] i, input logic fwd,
                                            input logic half);
        logic [2:0] base;
        base = i | 3'd1;
        if (half) next_idx = fwd ? i + 3'd1 : i - 3'd1;
        else      next_idx = fwd ? base + 3'd2 : base - 3'd2;
    endfunction

    // Next-state and registered-output computation for the move FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = 1'b0;
        counted = (state_q == RUN) && step_tick && enable && !abort;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (cmd.cmd_valid && ready_q) begin
                    rem_d   = cmd.cmd_steps;
                    dir_d   = cmd.cmd_dir;
                    ready_d = 1'b0;
                    if (cmd.cmd_steps == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_d = 1'b1;
                // Abort beats a coincident tick: that tick is not stepped.
                if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (counted) begin
                    idx_d = next_idx(idx_q, dir_q, half_step);
                    rem_d = rem_q - STEP_W'(1);
                    pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                // One-cycle DONE; ready comes back one cycle after IDLE is re-entered.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Coils follow the new index (holding torque in IDLE) unless de-energised.
        coil_d = enable ? phase_pat(idx_d) : 4'b0000;
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            coil_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            coil_q  <= coil_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign coil          = coil_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign position      = pos_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Directed bench for stepper_phase_driver: step sequences, zero move,
// enable gating, abort-vs-tick and mid-move reset.
`timescale 1ns/1ps
module tb_stepper_phase_driver;
    localparam int STEP_W = 16;
    localparam int POS_W  = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             step_tick, enable, half_step, abort;
    logic [3:0]       coil;
    logic             busy, done;
    logic [POS_W-1:0] position;
    int               total = 0;
    int               bad   = 0;
    int               done_cnt = 0;
    int               done_ref;

    stepper_phase_driver_if #(.STEP_W(STEP_W)) cmd_if ();

    stepper_phase_driver #(.STEP_W(STEP_W), .POS_W(POS_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .step_tick (step_tick),
        .enable    (enable),
        .half_step (half_step),
        .abort     (abort),
        .cmd       (cmd_if.slave),
        .coil      (coil),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clock = ~clock;

    // Count done pulses, sampled mid-cycle.
    always @(negedge clock) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
    endtask

    task automatic send(input logic [STEP_W-1:0] n, input logic d);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_steps = n;
        cmd_if.cmd_dir   = d;
        cyc();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        reset = 1'b0; step_tick = 1'b0; enable = 1'b0; half_step = 1'b1; abort = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_steps = '0; cmd_if.cmd_dir = 1'b0;
        repeat (2) cyc();
        chk("rst_coil",  32'(coil), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'h0);
        chk("rst_pos",   32'(position), 32'h0);

        // Half-step forward, 3 steps, ticks 5 cycles apart.
        reset = 1'b1; enable = 1'b1;
        cyc();
        chk("t1_ready", 32'(cmd_if.cmd_ready), 32'h1);
        chk("t1_hold",  32'(coil), 32'b1000);
        send(16'd3, 1'b1);
        chk("t1_busy",  32'(busy), 32'h1);
        chk("t1_nrdy",  32'(cmd_if.cmd_ready), 32'h0);
        tick();
        chk("t1_c1", 32'(coil), 32'b1100);
        repeat (4) cyc();
        tick();
        chk("t1_c2", 32'(coil), 32'b0100);
        repeat (4) cyc();
        done_ref = done_cnt;
        tick();
        chk("t1_c3",   32'(coil), 32'b0110);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_nbsy", 32'(busy), 32'h0);
        chk("t1_pos",  32'(position), 32'd3);
        cyc();
        chk("t1_done0", 32'(done), 32'h0);
        chk("t1_rdy0",  32'(cmd_if.cmd_ready), 32'h0);
        cyc();
        chk("t1_rdy1",  32'(cmd_if.cmd_ready), 32'h1);
        chk("t1_pulses", 32'(done_cnt - done_ref), 32'd1);

        // Full-step reverse from idx 0, 4 steps.
        do_reset();
        half_step = 1'b0;
        send(16'd4, 1'b0);
        tick(); chk("t2_c1", 32'(coil), 32'b1001);
        tick(); chk("t2_c2", 32'(coil), 32'b0011);
        tick(); chk("t2_c3", 32'(coil), 32'b0110);
        tick(); chk("t2_c4", 32'(coil), 32'b1100);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_pos",  32'(position), 32'hFFFC);
        repeat (2) cyc();
        chk("t2_rdy", 32'(cmd_if.cmd_ready), 32'h1);

        // Zero-step command: ready low two cycles, one done pulse, nothing moves.
        done_ref = done_cnt;
        send(16'd0, 1'b1);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_rdy0", 32'(cmd_if.cmd_ready), 32'h0);
        cyc();
        chk("t3_done0", 32'(done), 32'h0);
        chk("t3_rdy0b", 32'(cmd_if.cmd_ready), 32'h0);
        cyc();
        chk("t3_rdy1",  32'(cmd_if.cmd_ready), 32'h1);
        chk("t3_coil",  32'(coil), 32'b1100);
        chk("t3_pos",   32'(position), 32'hFFFC);
        chk("t3_pulses", 32'(done_cnt - done_ref), 32'd1);

        // Enable gating during a 5-step half-step move.
        do_reset();
        half_step = 1'b1;
        send(16'd5, 1'b1);
        enable = 1'b0;
        cyc();
        chk("t4_off", 32'(coil), 32'b0000);
        tick(); tick();
        chk("t4_off2", 32'(coil), 32'b0000);
        chk("t4_pos0", 32'(position), 32'd0);
        chk("t4_busy", 32'(busy), 32'h1);
        enable = 1'b1;
        cyc();
        chk("t4_on", 32'(coil), 32'b1000);
        repeat (4) tick();
        chk("t4_busy4", 32'(busy), 32'h1);
        chk("t4_pos4",  32'(position), 32'd4);
        tick();
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_pos5", 32'(position), 32'd5);
        chk("t4_coil", 32'(coil), 32'b0011);
        repeat (2) cyc();

        // Abort coincident with a tick: no step.
        send(16'd2, 1'b1);
        step_tick = 1'b1; abort = 1'b1;
        cyc();
        step_tick = 1'b0; abort = 1'b0;
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_pos",  32'(position), 32'd5);
        chk("t5_coil", 32'(coil), 32'b0011);
        repeat (2) cyc();

        // Reset mid-move after 2 of 10 steps.
        send(16'd10, 1'b1);
        tick(); tick();
        chk("t6_pos2", 32'(position), 32'd7);
        done_ref = done_cnt;
        #2 reset = 1'b0;
        #1;
        chk("t6_coil", 32'(coil), 32'b0000);
        chk("t6_pos",  32'(position), 32'd0);
        chk("t6_busy", 32'(busy), 32'h0);
        repeat (3) cyc();
        chk("t6_nodone", 32'(done_cnt - done_ref), 32'd0);
        reset = 1'b1;
        cyc();
        chk("t6_rdy", 32'(cmd_if.cmd_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stepper_phase_driver.md
Name: stepper_phase_driver

Overview:
- Consumes the one-cycle step ticks from the motor clock divider and turns them into unipolar stepper coil patterns for the 4-wire motor.
- Accepts move commands over a valid/ready handshake. Each command carries a step count and a direction.
- Advances the coil phase table once per tick until the count is exhausted, then signals completion.
- Tracks a signed absolute position for the UI/seven-segment logic.

Parameters:
- STEP_W, 16, width of the command step count and the remaining-step counter.
- POS_W, 16, width of the signed position counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- step_tick  in  1  one-cycle pulse from the clock divider; one tick is one step opportunity.
- enable  in  1  coil drive enable; 0 de-energises the coils.
- half_step  in  1  1 = 8-entry half-step table, 0 = 4-entry full-step (two-coil) table.
- cmd_valid  in  1  a move command is present.
- cmd_ready  out  1  the driver can accept a command.
- cmd_steps  in  STEP_W  number of steps to move.
- cmd_dir  in  1  1 = forward, 0 = reverse.
- abort  in  1  terminates the current move.
- coil  out  4  coil drive pattern, bit3 = A … bit0 = D.
- busy  out  1  a move is in progress.
- done  out  1  one-cycle pulse when a move ends, whether by completion or by abort.
- position  out  POS_W  signed absolute step count.

Behaviour:
- Reset values (while reset = 0): state = IDLE, phase index = 0, coil = 0000, busy = 0, done = 0, cmd_ready = 0, position = 0, remaining = 0.
- Half-step table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Full-step mode uses only the odd table entries.
- Index advance:
  - Half-step forward: idx+1 mod 8. Half-step reverse: idx-1 mod 8.
  - Full-step forward: (idx|1)+2 mod 8. Full-step reverse: (idx|1)-2 mod 8.
  - An even index is therefore snapped onto the odd sequence at the first full-step tick.
- coil is registered.
  - coil = table[idx] when enable = 1, otherwise 0000.
  - coil updates on the cycle after the event that changed idx or enable.
  - In IDLE with enable = 1, coil holds the current pattern (holding torque).
- IDLE state:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_steps into remaining and cmd_dir into dir.
  - If cmd_steps = 0, go to DONE; otherwise go to RUN.
- RUN state:
  - busy = 1, cmd_ready = 0.
  - A tick counts only when step_tick = 1, enable = 1 and abort = 0. On a counted tick:
    - idx advances per dir and half_step.
    - remaining decrements.
    - position changes by +1 (forward) or -1 (reverse), in two's complement, wrapping at the POS_W limits.
  - When a counted tick makes remaining reach 0, go to DONE.
  - step_tick while enable = 0: ignored; no step, remaining and position held.
  - abort = 1: go to DONE immediately. Abort wins over a simultaneous tick, so that tick produces no step.
- DONE state:
  - Lasts exactly one cycle, with done = 1 and busy = 0.
  - Then returns to IDLE; cmd_ready = 1 from the following cycle.
- cmd_valid while not ready: the command is not consumed, and the sender must hold it.
- half_step changing mid-move takes effect on the next counted tick.
- Reset asserted mid-move: immediate return to reset values; the move is lost and done is not pulsed.
- Max move is 2^STEP_W − 1 steps.

Test Plan:
- Reset, enable = 1, half_step = 1, command steps = 3, dir = 1, three ticks spaced 5 cycles apart → coil goes 1000 → 1100 → 0100 → 0110, position = 3, one done pulse, busy low afterwards, cmd_ready high.
- From idx 0, half_step = 0, command steps = 4, dir = 0 → coil 1001, 0011, 0110, 1100, back to idx 1 (1100); position = −4 (0xFFFC).
- Command steps = 0 → cmd_ready drops for 2 cycles, done pulses once, coil and position unchanged.
- During RUN with remaining = 5: drop enable and send 2 ticks → coil = 0000, remaining still 5. Re-enable, then 5 ticks → completes; position advances by exactly 5.
- abort asserted in the same cycle as step_tick with remaining = 2 → no step, done pulses next cycle, position unchanged.
- Reset pulled low during RUN after 2 of 10 steps → coil = 0000, position = 0, busy = 0 asynchronously; no done pulse.
